// File: rtl/mem_region_ctrl.sv
// Region decoder and wait-state sequencer for the on-chip ROM/RAM macros.
// Off-chip SRAM is only flagged here; its own controller sequences the access.
module mem_region_ctrl #(
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter int          ROM_AW    = 12,
    parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
    parameter int          SRAM_AW   = 20,
    parameter int          ROM_LAT   = 1,
    parameter int          RAM_LAT   = 1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              req,
    input  logic [31:0]       addr,
    input  logic              wen,
    input  logic [3:0]        byte_en,
    input  logic [31:0]       wdata,
    output logic              rom_active,
    output logic              ram_active,
    output logic              sram_active,
    output logic              rom_wait,
    output logic              ram_wait,
    output logic [31:0]       rom_rdata,
    output logic [31:0]       ram_rdata,
    output logic              err,
    output logic              rom_cs,
    output logic [ROM_AW-1:0] rom_a,
    input  logic [31:0]       rom_q,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [RAM_AW-1:0] ram_a,
    output logic [31:0]       ram_d,
    input  logic [31:0]       ram_q
);

    localparam int AW_MAX = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rom_rdata_q, rom_rdata_d;
    logic [31:0]       ram_rdata_q, ram_rdata_d;
    logic              ram_sel_q, ram_sel_d;
    logic              wen_q, wen_d;
    logic [AW_MAX-1:0] waddr_q, waddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic rom_hit, ram_hit, sram_hit, unmapped;
    logic access_rom, access_ram;
    logic unused_addr_lsbs;

    assign rom_hit  = (addr[31:ROM_AW+2]  == ROM_BASE[31:ROM_AW+2]);
    assign ram_hit  = (addr[31:RAM_AW+2]  == RAM_BASE[31:RAM_AW+2]);
    assign sram_hit = (addr[31:SRAM_AW+2] == SRAM_BASE[31:SRAM_AW+2]);
    assign unmapped = !rom_hit && !ram_hit && !sram_hit;
    assign unused_addr_lsbs = ^addr[1:0];

    assign rom_active  = rom_hit;
    assign ram_active  = ram_hit;
    assign sram_active = sram_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        rom_rdata_d = rom_rdata_q;
        ram_rdata_d = ram_rdata_q;
        ram_sel_d   = ram_sel_q;
        wen_d       = wen_q;
        waddr_d     = waddr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                // ROM writes are refused here and reported through err instead.
                if (req && ((rom_hit && !wen) || ram_hit)) begin
                    state_d   = ACCESS;
                    ram_sel_d = ram_hit;
                    wen_d     = wen;
                    waddr_d   = addr[AW_MAX+1:2];
                    be_d      = byte_en;
                    wdata_d   = wdata;
                    cnt_d     = ram_hit ? 4'(RAM_LAT) : 4'(ROM_LAT);
                end
                err_d = req && (unmapped || (rom_hit && wen));
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (!wen_q) begin
                        if (ram_sel_q) ram_rdata_d = ram_q;
                        else           rom_rdata_d = rom_q;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
            rom_rdata_q <= 32'hFFFF_FFFF;
            ram_rdata_q <= 32'hFFFF_FFFF;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rom_rdata_q <= rom_rdata_d;
            ram_rdata_q <= ram_rdata_d;
        end
    end

    // Request copy is only consumed while in ACCESS, so it needs no reset.
    always_ff @(posedge clk) begin
        ram_sel_q <= ram_sel_d;
        wen_q     <= wen_d;
        waddr_q   <= waddr_d;
        be_q      <= be_d;
        wdata_q   <= wdata_d;
    end

    assign access_rom = (state_q == ACCESS) && !ram_sel_q;
    assign access_ram = (state_q == ACCESS) &&  ram_sel_q;

    assign rom_cs = access_rom;
    assign rom_a  = waddr_q[ROM_AW-1:0];
    assign ram_cs = access_ram;
    assign ram_we = access_ram && wen_q && (cnt_q == 4'd1);
    assign ram_be = be_q;
    assign ram_a  = waddr_q[RAM_AW-1:0];
    assign ram_d  = wdata_q;

    // Wait is forced low while reset is held, even with a request pending.
    assign rom_wait = nRST && (access_rom || ((state_q == IDLE) && req && rom_hit && !wen));
    assign ram_wait = nRST && (access_ram || ((state_q == IDLE) && req && ram_hit));

    assign rom_rdata = rom_rdata_q;
    assign ram_rdata = ram_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Directed bench for mem_region_ctrl: one instance with ROM_LAT=3/RAM_LAT=1,
// a second with RAM_LAT=4 for the reset-during-write scenario.
module tb_mem_region_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRST, req, wen;
    logic [31:0] addr, wdata, rom_q, ram_q;
    logic [3:0]  byte_en;

    logic        rom_active, ram_active, sram_active, rom_wait, ram_wait, err;
    logic [31:0] rom_rdata, ram_rdata, ram_d;
    logic        rom_cs, ram_cs, ram_we;
    logic [11:0] rom_a;
    logic [13:0] ram_a;
    logic [3:0]  ram_be;

    logic        b_rom_active, b_ram_active, b_sram_active, b_rom_wait, b_ram_wait, b_err;
    logic [31:0] b_rom_rdata, b_ram_rdata, b_ram_d;
    logic        b_rom_cs, b_ram_cs, b_ram_we;
    logic [11:0] b_rom_a;
    logic [13:0] b_ram_a;
    logic [3:0]  b_ram_be;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int b_we_cnt = 0;

    mem_region_ctrl #(.ROM_LAT(3), .RAM_LAT(1)) u_dut (
        .clk(clk), .nRST(nRST), .req(req), .addr(addr), .wen(wen),
        .byte_en(byte_en), .wdata(wdata),
        .rom_active(rom_active), .ram_active(ram_active), .sram_active(sram_active),
        .rom_wait(rom_wait), .ram_wait(ram_wait),
        .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .err(err),
        .rom_cs(rom_cs), .rom_a(rom_a), .rom_q(rom_q),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be), .ram_a(ram_a),
        .ram_d(ram_d), .ram_q(ram_q)
    );

    mem_region_ctrl #(.ROM_LAT(3), .RAM_LAT(4)) u_dut4 (
        .clk(clk), .nRST(nRST), .req(req), .addr(addr), .wen(wen),
        .byte_en(byte_en), .wdata(wdata),
        .rom_active(b_rom_active), .ram_active(b_ram_active), .sram_active(b_sram_active),
        .rom_wait(b_rom_wait), .ram_wait(b_ram_wait),
        .rom_rdata(b_rom_rdata), .ram_rdata(b_ram_rdata), .err(b_err),
        .rom_cs(b_rom_cs), .rom_a(b_rom_a), .rom_q(rom_q),
        .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_be(b_ram_be), .ram_a(b_ram_a),
        .ram_d(b_ram_d), .ram_q(ram_q)
    );

    always @(posedge clk) begin
        if (ram_we)   we_cnt   <= we_cnt + 1;
        if (b_ram_we) b_we_cnt <= b_we_cnt + 1;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        nRST = 1'b0; req = 1'b0; wen = 1'b0; addr = 32'h0; wdata = 32'h0;
        byte_en = 4'h0; rom_q = 32'h0; ram_q = 32'h0;
        cyc(); #1;
        checks++;
        if (rom_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_rom_rdata got=%h exp=ffffffff", rom_rdata);
        end
        checks++;
        if (ram_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_ram_rdata got=%h exp=ffffffff", ram_rdata);
        end
        checks++;
        if ({rom_cs, ram_cs, ram_we, rom_wait, ram_wait, err} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000",
                               {rom_cs, ram_cs, ram_we, rom_wait, ram_wait, err});
        end
        cyc(); nRST = 1'b1;
    endtask

    task automatic test_ram_read();
        cyc(); req = 1'b1; wen = 1'b0; addr = 32'h2000_0010; ram_q = 32'hDEAD_BEEF; #1;
        checks++;
        if ({ram_active, ram_wait, ram_cs} !== 3'b110) begin
            errors++; $display("FAIL rd_c0 act/wait/cs got=%b exp=110", {ram_active, ram_wait, ram_cs});
        end
        cyc(); #1;
        checks++;
        if ({ram_wait, ram_cs} !== 2'b11 || ram_a !== 14'd4) begin
            errors++; $display("FAIL rd_c1 wait/cs=%b ram_a=%0d exp 11/4", {ram_wait, ram_cs}, ram_a);
        end
        cyc(); #1;
        checks++;
        if (ram_wait !== 1'b0 || ram_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_c2 wait=%b rdata=%h exp 0/deadbeef", ram_wait, ram_rdata);
        end
        cyc(); req = 1'b0;
    endtask

    task automatic test_ram_write();
        int n0;
        n0 = we_cnt;
        cyc(); req = 1'b1; wen = 1'b1; addr = 32'h2000_0004; byte_en = 4'b0011; wdata = 32'h1234_5678; #1;
        checks++;
        if ({ram_wait, ram_we} !== 2'b10) begin
            errors++; $display("FAIL wr_c0 wait/we got=%b exp=10", {ram_wait, ram_we});
        end
        cyc(); addr = 32'h2000_0100; #1;
        checks++;
        if (ram_we !== 1'b1 || ram_be !== 4'b0011 || ram_d !== 32'h1234_5678 || ram_a !== 14'd1) begin
            errors++; $display("FAIL wr_c1 we=%b be=%b d=%h a=%0d exp 1/0011/12345678/1",
                               ram_we, ram_be, ram_d, ram_a);
        end
        cyc(); #1;
        checks++;
        if ({ram_wait, ram_we} !== 2'b00 || ram_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL wr_c2 wait/we=%b rdata=%h exp 00/deadbeef", {ram_wait, ram_we}, ram_rdata);
        end
        cyc(); req = 1'b0; wen = 1'b0;
        cyc(); #1;
        checks++;
        if (we_cnt - n0 !== 1) begin
            errors++; $display("FAIL wr_pulses got=%0d exp=1", we_cnt - n0);
        end
    endtask

    task automatic test_rom_read();
        cyc(); req = 1'b1; wen = 1'b0; addr = 32'h0000_0FFC; rom_q = 32'hCAFE_F00D; #1;
        checks++;
        if ({rom_active, rom_wait, rom_cs} !== 3'b110) begin
            errors++; $display("FAIL rom_c0 act/wait/cs got=%b exp=110", {rom_active, rom_wait, rom_cs});
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(); #1;
            checks++;
            if ({rom_active, rom_wait, rom_cs} !== 3'b111 || rom_a !== 12'h3FF) begin
                errors++; $display("FAIL rom_c%0d act/wait/cs=%b a=%h exp 111/3ff",
                                   i, {rom_active, rom_wait, rom_cs}, rom_a);
            end
        end
        cyc(); #1;
        checks++;
        if ({rom_active, rom_wait, rom_cs} !== 3'b100 || rom_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL rom_c4 act/wait/cs=%b rdata=%h exp 100/cafef00d",
                               {rom_active, rom_wait, rom_cs}, rom_rdata);
        end
        cyc(); req = 1'b0;
    endtask

    task automatic test_errors();
        cyc(); req = 1'b1; wen = 1'b1; addr = 32'h0000_0000; #1;
        checks++;
        if ({rom_active, rom_wait, rom_cs, err} !== 4'b1000) begin
            errors++; $display("FAIL romwr_c0 act/wait/cs/err got=%b exp=1000",
                               {rom_active, rom_wait, rom_cs, err});
        end
        cyc(); req = 1'b0; wen = 1'b0; #1;
        checks++;
        if ({err, rom_cs} !== 2'b10) begin
            errors++; $display("FAIL romwr_c1 err/cs got=%b exp=10", {err, rom_cs});
        end
        cyc(); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL romwr_c2 err got=%b exp=0", err);
        end
        cyc(); req = 1'b1; addr = 32'h4000_0000; #1;
        checks++;
        if ({rom_active, ram_active, sram_active, rom_wait, ram_wait, rom_cs, ram_cs, err} !== 8'b0) begin
            errors++; $display("FAIL unmap_c0 flags got=%b exp=00000000",
                               {rom_active, ram_active, sram_active, rom_wait, ram_wait, rom_cs, ram_cs, err});
        end
        cyc(); #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL unmap_c1 err got=%b exp=1", err);
        end
        cyc(); req = 1'b0; #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL unmap_held err got=%b exp=1", err);
        end
        cyc(); #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL unmap_end err got=%b exp=0", err);
        end
    endtask

    task automatic test_sram();
        cyc(); req = 1'b1; wen = 1'b0; addr = 32'h8000_0000; #1;
        checks++;
        if ({sram_active, rom_active, ram_active, rom_wait, ram_wait, rom_cs, ram_cs} !== 7'b1000000) begin
            errors++; $display("FAIL sram_c0 flags got=%b exp=1000000",
                               {sram_active, rom_active, ram_active, rom_wait, ram_wait, rom_cs, ram_cs});
        end
        cyc(); #1;
        checks++;
        if ({err, rom_cs, ram_cs, ram_wait} !== 4'b0000) begin
            errors++; $display("FAIL sram_c1 err/cs/cs/wait got=%b exp=0000", {err, rom_cs, ram_cs, ram_wait});
        end
        cyc(); req = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int n0;
        cyc(); cyc();
        n0 = b_we_cnt;
        cyc(); req = 1'b1; wen = 1'b1; addr = 32'h2000_0000; byte_en = 4'hF; wdata = 32'hAAAA_5555; #1;
        checks++;
        if (b_ram_wait !== 1'b1) begin
            errors++; $display("FAIL rst_c0 wait got=%b exp=1", b_ram_wait);
        end
        cyc(); #1;
        checks++;
        if ({b_ram_cs, b_ram_we, b_ram_wait} !== 3'b101) begin
            errors++; $display("FAIL rst_c1 cs/we/wait got=%b exp=101", {b_ram_cs, b_ram_we, b_ram_wait});
        end
        cyc(); nRST = 1'b0; #1;
        checks++;
        if ({b_ram_cs, b_ram_we, b_ram_wait} !== 3'b000) begin
            errors++; $display("FAIL rst_async cs/we/wait got=%b exp=000", {b_ram_cs, b_ram_we, b_ram_wait});
        end
        cyc(); req = 1'b0; wen = 1'b0;
        cyc(); nRST = 1'b1;
        repeat (5) cyc();
        #1;
        checks++;
        if (b_we_cnt - n0 !== 0) begin
            errors++; $display("FAIL rst_unwritten we pulses got=%0d exp=0", b_we_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        cyc(); req = 1'b1; wen = 1'b0; addr = 32'h2000_0000; ram_q = 32'h1111_1111; #1;
        checks++;
        if (ram_wait !== 1'b1) begin
            errors++; $display("FAIL b2b_c0 wait got=%b exp=1", ram_wait);
        end
        cyc(); #1;
        checks++;
        if (ram_cs !== 1'b1 || ram_a !== 14'd0) begin
            errors++; $display("FAIL b2b_c1 cs=%b a=%0d exp 1/0", ram_cs, ram_a);
        end
        cyc(); #1;
        checks++;
        if ({ram_wait, ram_cs} !== 2'b00 || ram_rdata !== 32'h1111_1111) begin
            errors++; $display("FAIL b2b_done1 wait/cs=%b rdata=%h exp 00/11111111", {ram_wait, ram_cs}, ram_rdata);
        end
        cyc(); addr = 32'h2000_0008; ram_q = 32'h2222_2222; #1;
        checks++;
        if ({ram_wait, ram_cs} !== 2'b10) begin
            errors++; $display("FAIL b2b_accept2 wait/cs got=%b exp=10", {ram_wait, ram_cs});
        end
        cyc(); #1;
        checks++;
        if (ram_cs !== 1'b1 || ram_a !== 14'd2) begin
            errors++; $display("FAIL b2b_c4 cs=%b a=%0d exp 1/2", ram_cs, ram_a);
        end
        cyc(); #1;
        checks++;
        if (ram_wait !== 1'b0 || ram_rdata !== 32'h2222_2222) begin
            errors++; $display("FAIL b2b_done2 wait=%b rdata=%h exp 0/22222222", ram_wait, ram_rdata);
        end
        cyc(); req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_ram_write();
        test_rom_read();
        test_errors();
        test_sram();
        test_reset_mid_access();
        test_back_to_back();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
